// File: rtl/rc4_stream_engine.sv
// RC4-family stream cipher: W-bit symbols, optional keystream drop after KSA, and a
// ready/valid data path. The key is kept so a restart regenerates the same keystream.
module rc4_stream_engine #(
    parameter int unsigned W           = 8,
    parameter int unsigned KEY_MAX_LEN = 32,
    parameter int unsigned DROP_N      = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [W-1:0]     key_in,
    input  logic             restart,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [W-1:0]     din,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [W-1:0]     dout,
    output logic             ks_ready,
    output logic             key_ovf,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned N   = 1 << W;
    localparam int unsigned KLW = $clog2(KEY_MAX_LEN + 1);
    localparam int unsigned KIW = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;
    localparam int unsigned DW  = (DROP_N > 1) ? $clog2(DROP_N) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StInit, StKsa, StDrop, StRun} state_e;

    state_e           state_q;
    logic [W-1:0]     sbox_q [N];
    logic [W-1:0]     key_q [KEY_MAX_LEN];
    logic [W-1:0]     i_q;
    logic [W-1:0]     j_q;
    logic [KIW-1:0]   ki_q;
    logic [KLW-1:0]   key_len_q;
    logic [DW-1:0]    drop_cnt_q;
    logic             dout_valid_q;
    logic [W-1:0]     dout_q;
    logic             key_ovf_q;
    logic [CNT_W-1:0] word_cnt_q;

    logic [W-1:0]     ksa_si;
    logic [W-1:0]     ksa_j;
    logic [W-1:0]     ksa_sj;
    logic [KLW-1:0]   ki_inc;
    logic [KIW-1:0]   ki_next;
    logic [W-1:0]     prga_i;
    logic [W-1:0]     prga_a;
    logic [W-1:0]     prga_j;
    logic [W-1:0]     prga_b;
    logic [W-1:0]     prga_t;
    logic [W-1:0]     ks;

    logic             sw_en;
    logic [W-1:0]     sw_ia;
    logic [W-1:0]     sw_va;
    logic [W-1:0]     sw_ib;
    logic [W-1:0]     sw_vb;

    logic             accept;
    logic             key_we;
    logic [KIW-1:0]   key_waddr;

    // A word is not taken in the cycle a key load or restart pre-empts RUN.
    assign din_ready  = (state_q == StRun) && !key_valid && !restart &&
                        (!dout_valid_q || dout_ready);
    assign accept     = din_valid && din_ready;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign ks_ready   = (state_q == StRun);
    assign key_ovf    = key_ovf_q;
    assign word_cnt   = word_cnt_q;

    always_comb begin
        ksa_si  = sbox_q[i_q];
        ksa_j   = j_q + ksa_si + key_q[ki_q];
        ksa_sj  = sbox_q[ksa_j];
        ki_inc  = KLW'(ki_q) + KLW'(1);
        ki_next = (ki_inc == key_len_q) ? '0 : KIW'(ki_inc);

        prga_i  = i_q + W'(1);
        prga_a  = sbox_q[prga_i];
        prga_j  = j_q + prga_a;
        prga_b  = sbox_q[prga_j];
        prga_t  = prga_a + prga_b;
        // Keystream is read from the post-swap table, so forward the two swapped entries.
        ks      = sbox_q[prga_t];
        if (prga_t == prga_i) begin
            ks = prga_b;
        end else if (prga_t == prga_j) begin
            ks = prga_a;
        end
    end

    always_comb begin
        sw_en = 1'b0;
        sw_ia = prga_i;
        sw_va = prga_b;
        sw_ib = prga_j;
        sw_vb = prga_a;
        if (state_q == StKsa) begin
            sw_en = 1'b1;
            sw_ia = i_q;
            sw_va = ksa_sj;
            sw_ib = ksa_j;
            sw_vb = ksa_si;
        end else if (state_q == StDrop) begin
            sw_en = !restart;
        end else if (state_q == StRun) begin
            sw_en = accept;
        end
    end

    assign key_we    = key_valid &&
                       ((state_q == StIdle) || (state_q == StRun) ||
                        ((state_q == StLoad) && (key_len_q < KLW'(KEY_MAX_LEN))));
    assign key_waddr = (state_q == StLoad) ? KIW'(key_len_q) : '0;

    always_ff @(posedge clk) begin
        if (key_we) begin
            key_q[key_waddr] <= key_in;
        end
    end

    // When both swap indices coincide the two values are equal, so priority is irrelevant.
    always_ff @(posedge clk) begin
        for (int x = 0; x < N; x++) begin
            if (state_q == StInit) begin
                sbox_q[x] <= W'(x);
            end else if (sw_en && (sw_ia == W'(x))) begin
                sbox_q[x] <= sw_va;
            end else if (sw_en && (sw_ib == W'(x))) begin
                sbox_q[x] <= sw_vb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            i_q          <= '0;
            j_q          <= '0;
            ki_q         <= '0;
            key_len_q    <= '0;
            drop_cnt_q   <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            key_ovf_q    <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (key_valid) begin
                        state_q      <= StLoad;
                        key_len_q    <= KLW'(1);
                        key_ovf_q    <= 1'b0;
                        dout_valid_q <= 1'b0;
                        word_cnt_q   <= '0;
                    end
                end
                StLoad: begin
                    if (key_valid) begin
                        if (key_len_q < KLW'(KEY_MAX_LEN)) begin
                            key_len_q <= key_len_q + KLW'(1);
                        end else begin
                            key_ovf_q <= 1'b1;
                        end
                    end else begin
                        state_q <= StInit;
                    end
                end
                StInit: begin
                    i_q     <= '0;
                    j_q     <= '0;
                    ki_q    <= '0;
                    state_q <= StKsa;
                end
                StKsa: begin
                    i_q  <= i_q + W'(1);
                    j_q  <= ksa_j;
                    ki_q <= ki_next;
                    if (i_q == '1) begin
                        j_q        <= '0;
                        drop_cnt_q <= '0;
                        state_q    <= (DROP_N == 0) ? StRun : StDrop;
                    end
                end
                StDrop: begin
                    if (restart) begin
                        state_q      <= StInit;
                        dout_valid_q <= 1'b0;
                        word_cnt_q   <= '0;
                    end else begin
                        i_q        <= prga_i;
                        j_q        <= prga_j;
                        drop_cnt_q <= drop_cnt_q + DW'(1);
                        if (drop_cnt_q == DW'(DROP_N - 1)) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (key_valid) begin
                        state_q      <= StLoad;
                        key_len_q    <= KLW'(1);
                        key_ovf_q    <= 1'b0;
                        dout_valid_q <= 1'b0;
                        word_cnt_q   <= '0;
                    end else if (restart) begin
                        state_q      <= StInit;
                        dout_valid_q <= 1'b0;
                        word_cnt_q   <= '0;
                    end else if (accept) begin
                        i_q          <= prga_i;
                        j_q          <= prga_j;
                        dout_q       <= din ^ ks;
                        dout_valid_q <= 1'b1;
                        word_cnt_q   <= word_cnt_q + CNT_W'(1);
                    end else if (dout_ready) begin
                        dout_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
